// File: rtl/byte_bus_pkg.sv
// rtl/byte_bus_pkg.sv - shared state type and default sizing for the byte bus arbiter
package byte_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int N_DEF        = 4;
    localparam int WIDTH_DEF    = 8;
    localparam int MAX_HOLD_DEF = 4;

endpackage

// File: rtl/byte_bus_arbiter_rr_pick.sv
// rtl/byte_bus_arbiter_rr_pick.sv - combinational round-robin picker starting after 'last'
module rr_pick #(
    parameter int N  = 4,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    input  logic          exclude_en,
    input  logic [LW-1:0] exclude_idx,
    output logic          found,
    output logic [LW-1:0] idx
);

    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        // Scan last+1 .. last+N so the previous owner is considered last.
        for (int k = 1; k <= N; k++) begin
            j = (int'(last) + k) % N;
            if (!found && req[LW'(j)] && !(exclude_en && (j == int'(exclude_idx)))) begin
                found = 1'b1;
                idx   = LW'(j);
            end
        end
    end

endmodule

// File: rtl/byte_bus_arbiter.sv
// rtl/byte_bus_arbiter.sv - round-robin arbiter driving one registered shared byte bus
module byte_bus_arbiter
    import byte_bus_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid
);

    localparam int LW = $clog2(N);
    // With no hold limit the counter simply saturates at its own maximum.
    localparam int HW = (MAX_HOLD == 0) ? 4 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);

    state_e          state_q;
    logic [N-1:0]    grant_q;
    logic [LW-1:0]   owner_q;
    logic [LW-1:0]   last_q;
    logic [HW-1:0]   hold_q;
    logic [WIDTH-1:0] out_q;
    logic            valid_q;

    logic            idle_found;
    logic [LW-1:0]   idle_idx;
    logic            busy_found;
    logic [LW-1:0]   busy_idx;

    rr_pick #(.N(N), .LW(LW)) u_pick_idle (
        .req         (req),
        .last        (last_q),
        .exclude_en  (1'b0),
        .exclude_idx (owner_q),
        .found       (idle_found),
        .idx         (idle_idx)
    );

    // Handover path: scan after the owner and never re-pick it.
    rr_pick #(.N(N), .LW(LW)) u_pick_busy (
        .req         (req),
        .last        (owner_q),
        .exclude_en  (1'b1),
        .exclude_idx (owner_q),
        .found       (busy_found),
        .idx         (busy_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LW'(N - 1);
            hold_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if ((grant_q != '0) && req[owner_q]) begin
                out_q   <= in_data[int'(owner_q) * WIDTH +: WIDTH];
                valid_q <= 1'b1;
            end else begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (idle_found) begin
                        grant_q <= N'(1) << idle_idx;
                        owner_q <= idle_idx;
                        hold_q  <= HW'(1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req[owner_q]) begin
                        last_q <= owner_q;
                        if (busy_found) begin
                            grant_q <= N'(1) << busy_idx;
                            owner_q <= busy_idx;
                            hold_q  <= HW'(1);
                        end else begin
                            grant_q <= '0;
                            state_q <= IDLE;
                        end
                    end else if ((MAX_HOLD != 0) && (hold_q == HOLD_SAT) && busy_found) begin
                        last_q  <= owner_q;
                        grant_q <= N'(1) << busy_idx;
                        owner_q <= busy_idx;
                        hold_q  <= HW'(1);
                    end else if (hold_q != HOLD_SAT) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign owner     = owner_q;
    assign out       = out_q;
    assign out_valid = valid_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule

// File: tb/tb_byte_bus_arbiter.sv
// tb/tb_byte_bus_arbiter.sv - directed table-driven bench for byte_bus_arbiter
module tb_byte_bus_arbiter;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic [7:0]  out;
        logic        valid;
    } vec_t;

    localparam logic [31:0] DA = {8'h44, 8'h33, 8'h3C, 8'hA5};
    localparam logic [31:0] DB = {8'h44, 8'h33, 8'h77, 8'hA5};

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [3:0]  req_a, req_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  grant_a, grant_b;
    logic [1:0]  owner_a, owner_b;
    logic [7:0]  out_a, out_b;
    logic        valid_a, valid_b;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    byte_bus_arbiter #(.N(4), .WIDTH(8), .MAX_HOLD(4)) u_hold4 (
        .clk(clk), .rst(rst_a), .req(req_a), .in_data(data_a),
        .grant(grant_a), .owner(owner_a), .out(out_a), .out_valid(valid_a)
    );

    byte_bus_arbiter #(.N(4), .WIDTH(8), .MAX_HOLD(0)) u_unlim (
        .clk(clk), .rst(rst_b), .req(req_b), .in_data(data_b),
        .grant(grant_b), .owner(owner_b), .out(out_b), .out_valid(valid_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [31:0] d,
                       input logic [3:0] g, input logic [1:0] o, input logic [7:0] b, input logic v);
        vec_t t;
        t.rst = r; t.req = q; t.data = d; t.grant = g; t.owner = o; t.out = b; t.valid = v;
        tv.push_back(t);
    endtask

    logic [3:0] rr_req   [13];
    logic [3:0] rr_grant [13];

    initial begin
        rst_a = 1'b1; req_a = '0; data_a = DA;
        rst_b = 1'b1; req_b = '0; data_b = DA;

        // reset with all requesting, then requester 0 wins first
        add(1, 4'b1111, DA, 4'b0000, 0, 8'h00, 0);
        add(1, 4'b1111, DA, 4'b0000, 0, 8'h00, 0);
        add(0, 4'b1111, DA, 4'b0001, 0, 8'h00, 0);
        add(0, 4'b1111, DA, 4'b0001, 0, 8'hA5, 1);
        // forced rotation every 4 cycles between 0 and 1
        add(1, 4'b0011, DA, 4'b0000, 0, 8'h00, 0);
        add(0, 4'b0011, DA, 4'b0001, 0, 8'h00, 0);
        add(0, 4'b0011, DA, 4'b0001, 0, 8'hA5, 1);
        add(0, 4'b0011, DA, 4'b0001, 0, 8'hA5, 1);
        add(0, 4'b0011, DA, 4'b0001, 0, 8'hA5, 1);
        add(0, 4'b0011, DA, 4'b0010, 1, 8'hA5, 1);
        add(0, 4'b0011, DA, 4'b0010, 1, 8'h3C, 1);
        add(0, 4'b0011, DA, 4'b0010, 1, 8'h3C, 1);
        add(0, 4'b0011, DA, 4'b0010, 1, 8'h3C, 1);
        add(0, 4'b0011, DA, 4'b0001, 0, 8'h3C, 1);
        add(0, 4'b0011, DA, 4'b0001, 0, 8'hA5, 1);
        // sole requester keeps the bus for 10 cycles
        add(1, 4'b0100, DA, 4'b0000, 0, 8'h00, 0);
        add(0, 4'b0100, DA, 4'b0100, 2, 8'h00, 0);
        for (int i = 0; i < 9; i++) add(0, 4'b0100, DA, 4'b0100, 2, 8'h33, 1);
        // owner 0 releases exactly at hold limit while 2 waits
        add(1, 4'b0001, DA, 4'b0000, 0, 8'h00, 0);
        add(0, 4'b0001, DA, 4'b0001, 0, 8'h00, 0);
        add(0, 4'b0001, DA, 4'b0001, 0, 8'hA5, 1);
        add(0, 4'b0001, DA, 4'b0001, 0, 8'hA5, 1);
        add(0, 4'b0001, DA, 4'b0001, 0, 8'hA5, 1);
        add(0, 4'b0100, DA, 4'b0100, 2, 8'h00, 0);
        add(0, 4'b0100, DA, 4'b0100, 2, 8'h33, 1);
        // hand to requester 1 driving 77, then reset mid-transfer
        add(0, 4'b0010, DB, 4'b0010, 1, 8'h00, 0);
        add(0, 4'b0010, DB, 4'b0010, 1, 8'h77, 1);
        add(1, 4'b0010, DB, 4'b0000, 0, 8'h00, 0);
        add(0, 4'b1111, DB, 4'b0001, 0, 8'h00, 0);
        add(0, 4'b1111, DB, 4'b0001, 0, 8'hA5, 1);

        for (int i = 0; i < tv.size(); i++) begin
            rst_a  = tv[i].rst;
            req_a  = tv[i].req;
            data_a = tv[i].data;
            step();
            check($sformatf("v%0d.grant", i), 32'(grant_a), 32'(tv[i].grant));
            check($sformatf("v%0d.owner", i), 32'(owner_a), 32'(tv[i].owner));
            check($sformatf("v%0d.out",   i), 32'(out_a),   32'(tv[i].out));
            check($sformatf("v%0d.valid", i), 32'(valid_a), 32'(tv[i].valid));
        end

        // unlimited hold: zero-gap handovers 1 -> 3 -> 1, then no rotation
        rr_req   = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1010, 4'b1010, 4'b0010,
                     4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
        rr_grant = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b0010,
                     4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        rst_b = 1'b1; req_b = 4'b1010;
        step();
        check("rr.reset_grant", 32'(grant_b), 32'h0);
        rst_b = 1'b0;
        for (int i = 0; i < 13; i++) begin
            req_b = rr_req[i];
            step();
            check($sformatf("rr%0d.grant", i), 32'(grant_b), 32'(rr_grant[i]));
            if (i == 1) check("rr.out_d1", 32'(out_b), 32'h3C);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
